// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM arbiter: default geometry, watchdog limit
// and the CPU read-path state encoding.
package vram_arb_pkg;

  localparam int AW_DEF         = 16;
  localparam int DW_DEF         = 8;
  localparam int WAIT_LIMIT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    RD_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted-write buffer. A load in the same cycle as a drain wins,
// so the old entry leaves through the RAM port while the new one is captured.
module vram_wbuf
  import vram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = load_addr;
      data_d  = load_data;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM sharing: scanout owns every gpu_req cycle, the CPU uses the
// free slots through a posted-write buffer and a stalled read path.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          gpu_req,
  input  logic [AW-1:0] gpu_address,
  output logic [DW-1:0] gpu_data,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_re,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          starve,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          starve_q, starve_d;

  logic          free;
  logic          wbuf_v;
  logic [AW-1:0] wbuf_addr;
  logic [DW-1:0] wbuf_data;
  logic          wbuf_load;
  logic          wbuf_drain;
  logic          rd_issue;
  logic          pending;
  logic          op_done;

  assign free       = ~gpu_req;
  assign cpu_ready  = ~reset & (state_q == IDLE) & (~wbuf_v | free);
  assign wbuf_load  = cpu_we & cpu_ready;
  // Outputs are gated by reset so a dropped operation never reaches the RAM or the CPU.
  assign wbuf_drain = ~reset & free & wbuf_v;
  assign rd_issue   = ~reset & (state_q == RD_PEND) & free & ~wbuf_v;

  vram_wbuf #(
    .AW(AW),
    .DW(DW)
  ) u_wbuf (
    .clock    (clock),
    .reset    (reset),
    .load     (wbuf_load),
    .drain    (wbuf_drain),
    .load_addr(cpu_address),
    .load_data(cpu_wdata),
    .valid    (wbuf_v),
    .addr     (wbuf_addr),
    .data     (wbuf_data)
  );

  assign ram_we      = wbuf_drain;
  assign ram_wdata   = wbuf_data;
  assign ram_address = gpu_req ? gpu_address :
                       (wbuf_v ? wbuf_addr : (rd_issue ? rd_addr_q : gpu_address));
  assign gpu_data    = ram_rdata;

  // RAM data arrives in RD_DATA; forward it directly so rvalid lands two cycles after accept.
  assign cpu_rvalid  = ~reset & (state_q == RD_DATA);
  assign cpu_rdata   = cpu_rvalid ? ram_rdata : rdata_q;
  assign starve      = starve_q;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_re & cpu_ready) begin
          state_d   = RD_PEND;
          rd_addr_d = cpu_address;
        end
      end
      RD_PEND: begin
        if (rd_issue) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        rdata_d = ram_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending    = wbuf_v | (state_q == RD_PEND);
    op_done    = wbuf_drain | rd_issue;
    wait_cnt_d = wait_cnt_q;
    if (!pending || op_done) begin
      wait_cnt_d = 8'd0;
    end else if (gpu_req && (wait_cnt_q < LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    starve_d = starve_q | (wait_cnt_d == LIMIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= 8'd0;
      starve_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: vector table, directed corner sequences and a
// randomized run against a program-order memory model.
module tb_vram_arbiter;

  localparam int LIMIT = 64;

  logic        clock;
  logic        reset;
  logic        gpu_req;
  logic [15:0] gpu_address;
  logic [7:0]  gpu_data;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        starve;
  logic [15:0] ram_address;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  vram_arbiter #(
    .AW(16),
    .DW(8),
    .WAIT_LIMIT(LIMIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .gpu_req    (gpu_req),
    .gpu_address(gpu_address),
    .gpu_data   (gpu_data),
    .cpu_address(cpu_address),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .starve     (starve),
    .ram_address(ram_address),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Synchronous-read VRAM, 1-cycle latency, read-before-write.
  logic [7:0] mem [0:65535];
  logic       mem_init;
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
    end else if (ram_we) begin
      mem[ram_address] <= ram_wdata;
    end
    ram_rdata <= mem[ram_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_rd;
    logic [15:0] addr;
    logic [7:0]  data;      // write data, or expected read data
    logic [7:0]  gpu_mask;  // bit c = gpu_req in cycle c after the accept cycle 0
    int          exp_cycle; // cycle of ram_we (write) or cpu_rvalid (read)
  } vec_t;

  vec_t vecs [12];

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      gpu_req = 1'b0;
      cpu_we  = 1'b0;
      cpu_re  = 1'b0;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int hit;
    int hits;
    hit  = -1;
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      gpu_req     = (c < 8) ? v.gpu_mask[c] : 1'b0;
      gpu_address = 16'hF000 + 16'(c);
      cpu_we      = (c == 0) && !v.is_rd;
      cpu_re      = (c == 0) && v.is_rd;
      cpu_address = v.addr;
      cpu_wdata   = v.data;
      #1;
      if (c == 0) check("vec_accept", cpu_ready, 1);
      if (gpu_req) begin
        check("vec_gpu_addr", ram_address, gpu_address);
        check("vec_gpu_we", ram_we, 0);
      end
      if (!v.is_rd && ram_we) begin
        hits++;
        if (hit < 0) begin
          hit = c;
          check("vec_wr_addr", ram_address, v.addr);
          check("vec_wr_data", ram_wdata, v.data);
        end
      end
      if (v.is_rd && cpu_rvalid) begin
        hits++;
        if (hit < 0) begin
          hit = c;
          check("vec_rd_data", cpu_rdata, v.data);
        end
      end
    end
    check("vec_cycle", hit, v.exp_cycle);
    check("vec_count", hits, 1);
    $display("vec %0d %s addr=%h data=%h done_cycle=%0d", idx, v.is_rd ? "RD" : "WR", v.addr, v.data, hit);
  endtask

  // Random-phase model: program-order memory view plus slot rules.
  logic        wq_v, rd_p, rd_ret, starve_m;
  logic [15:0] wq_a, rd_a;
  logic [7:0]  wq_d, rd_x;
  logic [7:0]  shadow [0:7];
  int          run;
  logic        act, act_rd;
  logic [15:0] act_a;
  logic [7:0]  act_d;

  initial begin
    int wr_c, rd_acc, rv_c, b_acc, nd;
    int dc [2];
    logic [15:0] da [2];
    logic [7:0]  dd [2];
    logic exp_ready, exp_we, exp_issue, pend;

    vecs[0]  = '{1'b0, 16'h0010, 8'h3C, 8'h00, 1};
    vecs[1]  = '{1'b0, 16'h1234, 8'hA5, 8'h55, 1};
    vecs[2]  = '{1'b0, 16'hBEEF, 8'h3D, 8'h07, 3};
    vecs[3]  = '{1'b1, 16'h0010, 8'h3C, 8'h00, 2};
    vecs[4]  = '{1'b0, 16'h0040, 8'h5A, 8'h01, 1};
    vecs[5]  = '{1'b1, 16'h0040, 8'h5A, 8'h06, 4};
    vecs[6]  = '{1'b1, 16'h1234, 8'hA5, 8'h02, 3};
    vecs[7]  = '{1'b0, 16'h0000, 8'hFF, 8'hFE, 8};
    vecs[8]  = '{1'b0, 16'hFFFF, 8'h01, 8'h00, 1};
    vecs[9]  = '{1'b1, 16'hFFFF, 8'h01, 8'h01, 2};
    vecs[10] = '{1'b1, 16'h0000, 8'hFF, 8'hFF, 9};
    vecs[11] = '{1'b1, 16'hBEEF, 8'h3D, 8'h00, 2};

    reset       = 1'b1;
    mem_init    = 1'b1;
    gpu_req     = 1'b0;
    gpu_address = 16'h0000;
    cpu_address = 16'h0777;
    cpu_wdata   = 8'h11;
    cpu_we      = 1'b1;
    cpu_re      = 1'b0;

    // Reset state, with a write request held during reset.
    @(negedge clock);
    #1;
    check("rst_ready", cpu_ready, 0);
    check("rst_rvalid", cpu_rvalid, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_starve", starve, 0);
    check("rst_ram_we", ram_we, 0);
    @(negedge clock);
    reset    = 1'b0;
    mem_init = 1'b0;
    cpu_we   = 1'b0;
    #1;
    check("post_rst_ready", cpu_ready, 1);
    check("post_rst_ram_we", ram_we, 0);
    $display("reset sequence done");

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Write then immediate read of the same address, alternating slots.
    wr_c = -1; rd_acc = -1; rv_c = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      gpu_req     = (c % 2 == 0);
      gpu_address = 16'hE000 + 16'(c);
      cpu_we      = (c == 0);
      cpu_re      = (c >= 1) && (rd_acc < 0);
      cpu_address = 16'h0020;
      cpu_wdata   = 8'h77;
      #1;
      if (c == 0) check("t3_wr_ready", cpu_ready, 1);
      if (gpu_req) check("t3_gpu_addr", ram_address, gpu_address);
      if (ram_we && wr_c < 0) begin
        wr_c = c;
        check("t3_wr_addr", ram_address, 16'h0020);
        check("t3_wr_data", ram_wdata, 8'h77);
      end
      if (cpu_re && cpu_ready) rd_acc = c;
      if (cpu_rvalid) begin
        rv_c = c;
        check("t3_rd_data", cpu_rdata, 8'h77);
      end
    end
    check("t3_wr_cycle", wr_c, 1);
    check("t3_rd_accept", rd_acc, 1);
    check("t3_rvalid_cycle", rv_c, 4);
    $display("raw write 0020<-77 drained c%0d, read accepted c%0d, rvalid c%0d", wr_c, rd_acc, rv_c);

    // Back-to-back writes while scanout holds the port.
    b_acc = -1; nd = 0;
    dc[0] = -1; dc[1] = -1; da[0] = '0; da[1] = '0; dd[0] = '0; dd[1] = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      gpu_req     = (c < 5);
      gpu_address = 16'hD000 + 16'(c);
      cpu_re      = 1'b0;
      cpu_we      = (c == 0) || ((c >= 1) && (b_acc < 0));
      cpu_address = (c == 0) ? 16'h0300 : 16'h0301;
      cpu_wdata   = (c == 0) ? 8'h11 : 8'h22;
      #1;
      if (c == 1) check("t4_ready_blocked", cpu_ready, 0);
      if (c >= 1 && b_acc < 0 && cpu_ready) b_acc = c;
      if (ram_we) begin
        if (nd < 2) begin
          dc[nd] = c;
          da[nd] = ram_address;
          dd[nd] = ram_wdata;
        end
        nd++;
      end
    end
    check("t4_second_accept", b_acc, 5);
    check("t4_drain_count", nd, 2);
    check("t4_first_cycle", dc[0], 5);
    check("t4_first_addr", da[0], 16'h0300);
    check("t4_first_data", dd[0], 8'h11);
    check("t4_second_cycle", dc[1], 6);
    check("t4_second_addr", da[1], 16'h0301);
    check("t4_second_data", dd[1], 8'h22);
    $display("b2b writes 0300<-11, 0301<-22 drained c%0d/c%0d", dc[0], dc[1]);

    // Randomized traffic against the model.
    idle_cycles(3);
    wq_v = 1'b0; rd_p = 1'b0; rd_ret = 1'b0; starve_m = 1'b0; run = 0;
    wq_a = '0; wq_d = '0; rd_a = '0; rd_x = '0;
    act = 1'b0; act_rd = 1'b0; act_a = '0; act_d = '0;
    for (int i = 0; i < 8; i++) shadow[i] = init_val(16'h0200 + 16'(i));
    for (int n = 0; n < 1500; n++) begin
      @(negedge clock);
      if (!act && ($urandom_range(0, 2) == 0)) begin
        act    = 1'b1;
        act_rd = ($urandom_range(0, 1) == 1);
        act_a  = 16'h0200 + 16'($urandom_range(0, 7));
        act_d  = 8'($urandom);
      end
      gpu_req     = ($urandom_range(0, 9) < 6);
      gpu_address = 16'($urandom);
      cpu_we      = act && !act_rd;
      cpu_re      = act && act_rd;
      cpu_address = act_a;
      cpu_wdata   = act_d;
      #1;
      exp_ready = !rd_p && !rd_ret && (!wq_v || !gpu_req);
      exp_we    = wq_v && !gpu_req;
      exp_issue = rd_p && !gpu_req && !wq_v;
      check("rnd_ready", cpu_ready, exp_ready);
      check("rnd_ram_we", ram_we, exp_we);
      check("rnd_rvalid", cpu_rvalid, rd_ret);
      if (exp_we) begin
        check("rnd_wr_addr", ram_address, wq_a);
        check("rnd_wr_data", ram_wdata, wq_d);
      end else if (gpu_req) begin
        check("rnd_gpu_addr", ram_address, gpu_address);
      end else if (exp_issue) begin
        check("rnd_rd_addr", ram_address, rd_a);
      end
      if (rd_ret) check("rnd_rd_data", cpu_rdata, rd_x);
      check("rnd_starve", starve, starve_m);
      check("rnd_gpu_data", gpu_data, ram_rdata);

      pend = wq_v || rd_p;
      if (!pend || exp_we || exp_issue) run = 0;
      else if (gpu_req && run < LIMIT) run++;
      if (run == LIMIT) starve_m = 1'b1;
      rd_ret = exp_issue;
      if (exp_issue) rd_p = 1'b0;
      if (exp_we) wq_v = 1'b0;
      if (act && exp_ready) begin
        if (act_rd) begin
          rd_p = 1'b1;
          rd_a = act_a;
          rd_x = shadow[act_a[2:0]];
        end else begin
          wq_v = 1'b1;
          wq_a = act_a;
          wq_d = act_d;
          shadow[act_a[2:0]] = act_d;
        end
        $display("rnd %0d %s addr=%h data=%h", n, act_rd ? "RD" : "WR", act_a, act_rd ? rd_x : act_d);
      end
      if (act && cpu_ready) act = 1'b0;
    end

    // Starvation watchdog: write blocked by 100 scanout cycles.
    idle_cycles(4);
    for (int c = 0; c < 104; c++) begin
      @(negedge clock);
      gpu_req     = (c < 100);
      gpu_address = 16'hC000 + 16'(c);
      cpu_re      = 1'b0;
      cpu_we      = (c == 0);
      cpu_address = 16'h0400;
      cpu_wdata   = 8'h5C;
      #1;
      if (c == 0) begin
        check("t5_ready", cpu_ready, 1);
        check("t5_starve_init", starve, 0);
      end
      if (c == 64) check("t5_starve_before", starve, 0);
      if (c == 65) check("t5_starve_set", starve, 1);
      if (c == 100) begin
        check("t5_drain", ram_we, 1);
        check("t5_drain_addr", ram_address, 16'h0400);
      end
      if (c == 103) check("t5_sticky", starve, 1);
    end
    $display("starve test write 0400<-5C, starve=%0b", starve);

    // Reset while a read is pending.
    @(negedge clock);
    gpu_req = 1'b1; cpu_we = 1'b0; cpu_re = 1'b1; cpu_address = 16'h0010;
    #1;
    check("t6_rd_accept", cpu_ready, 1);
    @(negedge clock);
    cpu_re = 1'b0; reset = 1'b1;
    #1;
    check("t6_ready_in_reset", cpu_ready, 0);
    for (int c = 2; c < 6; c++) begin
      @(negedge clock);
      reset = 1'b0; gpu_req = 1'b0; gpu_address = 16'hB000 + 16'(c);
      #1;
      check("t6_no_rvalid", cpu_rvalid, 0);
      if (c == 2) begin
        check("t6_ready_after", cpu_ready, 1);
        check("t6_no_issue", ram_address, gpu_address);
        check("t6_starve_clr", starve, 0);
      end
    end
    $display("reset during read pending: read dropped");

    // Reset while a write is buffered.
    @(negedge clock);
    gpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 16'h0500; cpu_wdata = 8'h99;
    #1;
    check("t6_wr_accept", cpu_ready, 1);
    @(negedge clock);
    cpu_we = 1'b0; reset = 1'b1;
    #1;
    check("t6_we_in_reset", ram_we, 0);
    for (int c = 2; c < 6; c++) begin
      @(negedge clock);
      reset = 1'b0; gpu_req = 1'b0;
      #1;
      check("t6_write_lost", ram_we, 0);
    end
    $display("reset during buffered write: write dropped");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
